// File: rtl/reorder_commit_tracker_if.sv
// Bus bundle for reorder_commit_tracker: allocation, operation steering, completion and commit handshake.
interface reorder_commit_tracker_if #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ID_WIDTH   = 3
);
  localparam int unsigned SEL_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [ID_WIDTH-1:0]   alloc_id_i;
  logic                  op_push_i;
  logic [SEL_WIDTH-1:0]  op_sel_i;
  logic                  op_ready_o;
  logic                  close_i;
  logic [NUM_QUEUES-1:0] queues_done_i;
  logic                  commit_valid_o;
  logic [ID_WIDTH-1:0]   commit_id_o;
  logic                  commit_ready_i;
  logic                  full_o;
  logic                  empty_o;
  logic [PTR_WIDTH:0]    count_o;
  logic                  err_o;
  logic                  timeout_o;

  modport master (
    output alloc_valid_i, alloc_id_i, op_push_i, op_sel_i, close_i, queues_done_i, commit_ready_i,
    input  alloc_ready_o, op_ready_o, commit_valid_o, commit_id_o, full_o, empty_o, count_o, err_o, timeout_o
  );

  modport slave (
    input  alloc_valid_i, alloc_id_i, op_push_i, op_sel_i, close_i, queues_done_i, commit_ready_i,
    output alloc_ready_o, op_ready_o, commit_valid_o, commit_id_o, full_o, empty_o, count_o, err_o, timeout_o
  );
endinterface

// File: rtl/reorder_commit_tracker.sv
// In-order commit tracker: entries collect per-queue pending ops and retire oldest-first once closed and drained.
// Optional head watchdog enabled by defining REORDER_HEAD_TIMEOUT_EN.
module reorder_commit_tracker #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH  = 3
`ifdef REORDER_HEAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 255
`endif
) (
  input logic                clk_i,
  input logic                arsn_i,
  reorder_commit_tracker_if.slave bus
);
  localparam int unsigned SEL_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CW        = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CW-1:0]        head_q, tail_q;
  logic                 ent_valid_q [DEPTH];
  logic                 ent_open_q  [DEPTH];
  logic [ID_WIDTH-1:0]  ent_id_q    [DEPTH];
  logic [CNT_WIDTH-1:0] ent_cnt_q   [DEPTH][NUM_QUEUES];
  logic                 err_q;

  logic [PTR_WIDTH-1:0]  head_idx, tail_idx, open_idx;
  logic [SEL_WIDTH-1:0]  sel_idx;
  logic [CW-1:0]         count;
  logic                  full, empty, open_exists, sel_ok, op_ready;
  logic                  push_fire, push_drop, close_fire, alloc_fire, commit_valid, commit_fire;
  logic                  head_drained, done_miss;
  logic [NUM_QUEUES-1:0] found;
  logic [NUM_QUEUES-1:0] inc [DEPTH];
  logic [NUM_QUEUES-1:0] dec [DEPTH];

  assign head_idx    = head_q[PTR_WIDTH-1:0];
  assign tail_idx    = tail_q[PTR_WIDTH-1:0];
  assign open_idx    = tail_idx - PTR_WIDTH'(1);
  assign count       = tail_q - head_q;
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign open_exists = ent_valid_q[open_idx] && ent_open_q[open_idx];
  assign sel_ok      = (int'(bus.op_sel_i) < int'(NUM_QUEUES));
  assign sel_idx     = sel_ok ? bus.op_sel_i : '0;
  assign op_ready    = open_exists && sel_ok && (ent_cnt_q[open_idx][sel_idx] != CNT_MAX);

  assign push_fire   = bus.op_push_i && op_ready;
  assign push_drop   = bus.op_push_i && !op_ready;
  assign close_fire  = bus.close_i && open_exists;
  assign alloc_fire  = bus.alloc_valid_i && !full;
  assign commit_valid = ent_valid_q[head_idx] && !ent_open_q[head_idx] && head_drained;
  assign commit_fire = commit_valid && bus.commit_ready_i;

  // Per-queue completion steering: oldest valid entry (from head) with a nonzero counter takes the pulse.
  always_comb begin
    head_drained = 1'b1;
    done_miss    = 1'b0;
    found        = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      inc[i] = '0;
      dec[i] = '0;
    end
    for (int q = 0; q < int'(NUM_QUEUES); q++) begin
      if (ent_cnt_q[head_idx][q] != '0) head_drained = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (bus.queues_done_i[q] && !found[q] &&
            ent_valid_q[head_idx + PTR_WIDTH'(i)] &&
            ent_cnt_q[head_idx + PTR_WIDTH'(i)][q] != '0) begin
          dec[head_idx + PTR_WIDTH'(i)][q] = 1'b1;
          found[q] = 1'b1;
        end
      end
      if (bus.queues_done_i[q] && !found[q]) done_miss = 1'b1;
    end
    if (push_fire) inc[open_idx][sel_idx] = 1'b1;
  end

  // Entry storage and pointers; alloc is applied after push/close so they hit the previously open entry.
  always_ff @(posedge clk_i or negedge arsn_i) begin
    if (!arsn_i) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_valid_q[i] <= 1'b0;
        ent_open_q[i]  <= 1'b0;
        ent_id_q[i]    <= '0;
        for (int q = 0; q < int'(NUM_QUEUES); q++) ent_cnt_q[i][q] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        for (int q = 0; q < int'(NUM_QUEUES); q++) begin
          if (inc[i][q] && !dec[i][q])      ent_cnt_q[i][q] <= ent_cnt_q[i][q] + CNT_WIDTH'(1);
          else if (!inc[i][q] && dec[i][q]) ent_cnt_q[i][q] <= ent_cnt_q[i][q] - CNT_WIDTH'(1);
        end
      end
      if (close_fire || (alloc_fire && open_exists)) ent_open_q[open_idx] <= 1'b0;
      if (alloc_fire) begin
        ent_valid_q[tail_idx] <= 1'b1;
        ent_open_q[tail_idx]  <= 1'b1;
        ent_id_q[tail_idx]    <= bus.alloc_id_i;
        tail_q                <= tail_q + CW'(1);
      end
      if (commit_fire) begin
        ent_valid_q[head_idx] <= 1'b0;
        head_q                <= head_q + CW'(1);
      end
      if (push_drop || done_miss) err_q <= 1'b1;
    end
  end

  assign bus.alloc_ready_o  = !full;
  assign bus.op_ready_o     = op_ready;
  assign bus.commit_valid_o = commit_valid;
  assign bus.commit_id_o    = ent_id_q[head_idx];
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.count_o        = count;
  assign bus.err_o          = err_q;

`ifdef REORDER_HEAD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wd_q;
  logic          tmo_q;

  // Head watchdog: restarts on retirement, saturates at TIMEOUT, flag holds until the head leaves.
  always_ff @(posedge clk_i or negedge arsn_i) begin
    if (!arsn_i) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else if (commit_fire) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else if (!empty && !commit_valid) begin
      if (wd_q != TW'(TIMEOUT)) wd_q <= wd_q + TW'(1);
      if (wd_q >= TW'(TIMEOUT - 1)) tmo_q <= 1'b1;
    end
  end

  assign bus.timeout_o = tmo_q;
`else
  assign bus.timeout_o = 1'b0;
`endif
endmodule
